// File: rtl/fcp_master_logical_layer.sv
// FCP initiator logical layer: host register request -> ping/command -> slave ping/response -> status.
// Latency: ping strobe 1 cycle after cmd_req; cmd_done 2 cycles after the accepted response.
// Backpressure: none; cmd_req is dropped while busy, and PL events outside their consuming state are ignored.
module fcp_master_logical_layer #(
  parameter int TIMEOUT   = 2000,
  parameter int MAX_RETRY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_req,
  input  logic        cmd_wr,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        busy,
  output logic        cmd_done,
  output logic [1:0]  cmd_status,
  output logic [7:0]  cmd_rdata,
  output logic        pl_tx_en,
  output logic        pl_tx_type,
  output logic [23:0] pl_tx_data,
  output logic        pl_tx_reset,
  input  logic        tx_done,
  input  logic        ping_from_slave,
  input  logic [15:0] rx_data,
  input  logic        rx_data_valid,
  input  logic        crc_error,
  input  logic        par_error
);

  localparam logic [15:0] TIMEOUT_V   = 16'(TIMEOUT);
  localparam logic [1:0]  MAX_RETRY_V = 2'(MAX_RETRY);
  localparam logic [7:0]  RESP_ACK    = 8'h08;
  localparam logic [1:0]  ST_ACK      = 2'b00;
  localparam logic [1:0]  ST_NACK     = 2'b01;
  localparam logic [1:0]  ST_TIMEOUT  = 2'b10;
  localparam logic [1:0]  ST_LINK     = 2'b11;

  typedef enum logic [2:0] {IDLE, TX_PING, TX_CMD, WAIT_SPING, WAIT_RESP, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d, timer_inc;
  logic [1:0]  retry_q, retry_d;
  logic        wr_q, wr_d;
  logic [7:0]  addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]  res_status_q, res_status_d;
  logic [7:0]  res_rdata_q, res_rdata_d;
  logic        busy_d, cmd_done_d, tx_en_d, tx_type_d, tx_reset_d;
  logic [1:0]  cmd_status_d;
  logic [7:0]  cmd_rdata_d;
  logic [23:0] tx_data_d;
  logic        fault;
  logic [1:0]  fault_code;
  logic [7:0]  resp;
  logic [23:0] frame;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    res_status_d = res_status_q;
    res_rdata_d  = res_rdata_q;
    busy_d       = busy;
    cmd_done_d   = 1'b0;
    cmd_status_d = cmd_status;
    cmd_rdata_d  = cmd_rdata;
    tx_en_d      = 1'b0;
    tx_type_d    = pl_tx_type;
    tx_data_d    = pl_tx_data;
    tx_reset_d   = 1'b0;
    fault        = 1'b0;
    fault_code   = ST_TIMEOUT;
    timer_inc    = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
    resp         = wr_q ? rx_data[7:0] : rx_data[15:8];
    frame        = wr_q ? {8'h0B, addr_q, wdata_q} : {8'h00, 8'h0C, addr_q};

    // busy covers the cmd_done cycle, so IDLE cannot accept until the cycle after it
    if (cmd_done) busy_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_req && !busy) begin
          wr_d      = cmd_wr;
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          retry_d   = 2'd0;
          busy_d    = 1'b1;
          tx_en_d   = 1'b1;
          tx_type_d = 1'b0;
          state_d   = TX_PING;
        end
      end
      TX_PING: begin
        if (tx_done) begin
          tx_en_d   = 1'b1;
          tx_type_d = 1'b1;
          tx_data_d = frame;
          state_d   = TX_CMD;
        end
      end
      TX_CMD: begin
        if (tx_done) begin
          timer_d = 16'd0;
          state_d = WAIT_SPING;
        end
      end
      WAIT_SPING: begin
        timer_d = timer_inc;
        if (ping_from_slave) begin
          timer_d = 16'd0;
          state_d = WAIT_RESP;
        end else if (timer_q == TIMEOUT_V) begin
          fault = 1'b1;
        end
      end
      WAIT_RESP: begin
        timer_d = timer_inc;
        if (crc_error || par_error) begin
          fault      = 1'b1;
          fault_code = ST_LINK;
        end else if (rx_data_valid) begin
          res_status_d = (resp == RESP_ACK) ? ST_ACK : ST_NACK;
          res_rdata_d  = (resp == RESP_ACK && !wr_q) ? rx_data[7:0] : 8'h00;
          state_d      = DONE;
        end else if (timer_q == TIMEOUT_V) begin
          fault = 1'b1;
        end
      end
      DONE: begin
        cmd_done_d   = 1'b1;
        cmd_status_d = res_status_q;
        cmd_rdata_d  = res_rdata_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fault) begin
      timer_d = 16'd0;
      if (retry_q < MAX_RETRY_V) begin
        retry_d   = retry_q + 2'd1;
        tx_en_d   = 1'b1;
        tx_type_d = 1'b0;
        state_d   = TX_PING;
      end else begin
        tx_reset_d   = 1'b1;
        res_status_d = fault_code;
        res_rdata_d  = 8'h00;
        state_d      = DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= 16'd0;
      retry_q      <= 2'd0;
      wr_q         <= 1'b0;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      res_status_q <= ST_ACK;
      res_rdata_q  <= 8'h00;
      busy         <= 1'b0;
      cmd_done     <= 1'b0;
      cmd_status   <= ST_ACK;
      cmd_rdata    <= 8'h00;
      pl_tx_en     <= 1'b0;
      pl_tx_type   <= 1'b0;
      pl_tx_data   <= 24'h000000;
      pl_tx_reset  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      res_status_q <= res_status_d;
      res_rdata_q  <= res_rdata_d;
      busy         <= busy_d;
      cmd_done     <= cmd_done_d;
      cmd_status   <= cmd_status_d;
      cmd_rdata    <= cmd_rdata_d;
      pl_tx_en     <= tx_en_d;
      pl_tx_type   <= tx_type_d;
      pl_tx_data   <= tx_data_d;
      pl_tx_reset  <= tx_reset_d;
    end
  end

endmodule

// File: tb/tb_fcp_master_logical_layer.sv
// Directed bench for fcp_master_logical_layer with TIMEOUT=20, MAX_RETRY=2.
module tb_fcp_master_logical_layer;
  localparam int TO = 20;
  localparam int MR = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_req, cmd_wr;
  logic [7:0]  cmd_addr, cmd_wdata;
  logic        busy, cmd_done;
  logic [1:0]  cmd_status;
  logic [7:0]  cmd_rdata;
  logic        pl_tx_en, pl_tx_type, pl_tx_reset;
  logic [23:0] pl_tx_data;
  logic        tx_done, ping_from_slave, rx_data_valid, crc_error, par_error;
  logic [15:0] rx_data;

  int tests_run = 0;
  int tests_failed = 0;
  int ping_cnt = 0;
  int frame_cnt = 0;
  int reset_cnt = 0;
  int done_cnt = 0;

  fcp_master_logical_layer #(.TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .busy(busy), .cmd_done(cmd_done), .cmd_status(cmd_status),
    .cmd_rdata(cmd_rdata), .pl_tx_en(pl_tx_en), .pl_tx_type(pl_tx_type),
    .pl_tx_data(pl_tx_data), .pl_tx_reset(pl_tx_reset), .tx_done(tx_done),
    .ping_from_slave(ping_from_slave), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .crc_error(crc_error), .par_error(par_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pl_tx_en && !pl_tx_type) ping_cnt++;
    if (pl_tx_en && pl_tx_type) frame_cnt++;
    if (pl_tx_reset) reset_cnt++;
    if (cmd_done) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic wr, input logic [7:0] a, input logic [7:0] d);
    cmd_req = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_req = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic pulse_sping();
    ping_from_slave = 1'b1;
    tick();
    ping_from_slave = 1'b0;
  endtask

  task automatic pulse_rx(input logic [15:0] d, input logic crc, input logic par);
    rx_data = d; rx_data_valid = 1'b1; crc_error = crc; par_error = par;
    tick();
    rx_data_valid = 1'b0; crc_error = 1'b0; par_error = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({busy, cmd_done, cmd_status, cmd_rdata, pl_tx_en, pl_tx_type, pl_tx_data, pl_tx_reset} !== 39'd0) begin
      tests_failed++;
      $display("FAIL reset_values: busy=%b done=%b st=%b rd=%h en=%b ty=%b dat=%h rst=%b, all zero required",
               busy, cmd_done, cmd_status, cmd_rdata, pl_tx_en, pl_tx_type, pl_tx_data, pl_tx_reset);
    end
    rst = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({busy, cmd_done, pl_tx_en, pl_tx_reset} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL idle_after_reset: busy/done/en/rst=%b, required 0000", {busy, cmd_done, pl_tx_en, pl_tx_reset});
    end
  endtask

  task automatic test_write();
    int p0 = ping_cnt;
    pulse_req(1'b1, 8'h2C, 8'd90);
    tests_run++;
    if ({busy, pl_tx_en, pl_tx_type} !== 3'b110) begin
      tests_failed++;
      $display("FAIL wr_ping_strobe: busy/en/type=%b, required 110", {busy, pl_tx_en, pl_tx_type});
    end
    pulse_tx_done();
    tests_run++;
    if ({pl_tx_en, pl_tx_type, pl_tx_data} !== {2'b11, 24'h0B2C5A}) begin
      tests_failed++;
      $display("FAIL wr_frame: en/type=%b data=%h, required 11 0b2c5a", {pl_tx_en, pl_tx_type}, pl_tx_data);
    end
    pulse_tx_done();
    pulse_sping();
    pulse_rx(16'h0008, 1'b0, 1'b0);
    tests_run++;
    if (cmd_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_done_early: cmd_done=%b in decode cycle, required 0", cmd_done);
    end
    tick();
    tests_run++;
    if ({cmd_done, busy, cmd_status, cmd_rdata} !== {1'b1, 1'b1, 2'b00, 8'h00}) begin
      tests_failed++;
      $display("FAIL wr_done: done=%b busy=%b st=%b rd=%h, required 1 1 00 00", cmd_done, busy, cmd_status, cmd_rdata);
    end
    tick();
    tests_run++;
    if ({cmd_done, busy, cmd_status} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL wr_after_done: done/busy/st=%b, required 0000", {cmd_done, busy, cmd_status});
    end
    tests_run++;
    if (ping_cnt - p0 !== 1) begin
      tests_failed++;
      $display("FAIL wr_pings: %0d pings, required 1", ping_cnt - p0);
    end
  endtask

  task automatic test_read();
    pulse_req(1'b0, 8'h29, 8'hFF);
    pulse_tx_done();
    tests_run++;
    if ({pl_tx_en, pl_tx_type, pl_tx_data} !== {2'b11, 24'h000C29}) begin
      tests_failed++;
      $display("FAIL rd_frame: en/type=%b data=%h, required 11 000c29", {pl_tx_en, pl_tx_type}, pl_tx_data);
    end
    pulse_tx_done();
    pulse_sping();
    pulse_rx(16'h085A, 1'b0, 1'b0);
    tick();
    tests_run++;
    if ({cmd_done, cmd_status, cmd_rdata} !== {1'b1, 2'b00, 8'h5A}) begin
      tests_failed++;
      $display("FAIL rd_ack: done=%b st=%b rd=%h, required 1 00 5a", cmd_done, cmd_status, cmd_rdata);
    end
    tick();
  endtask

  task automatic test_nack();
    int p0 = ping_cnt;
    int r0 = reset_cnt;
    pulse_req(1'b0, 8'h40, 8'h00);
    pulse_tx_done();
    pulse_tx_done();
    pulse_sping();
    pulse_rx(16'h0300, 1'b0, 1'b0);
    tick();
    tests_run++;
    if ({cmd_done, cmd_status, cmd_rdata} !== {1'b1, 2'b01, 8'h00}) begin
      tests_failed++;
      $display("FAIL rd_nack: done=%b st=%b rd=%h, required 1 01 00", cmd_done, cmd_status, cmd_rdata);
    end
    tick();
    tick();
    tick();
    tests_run++;
    if ((ping_cnt - p0 !== 1) || (reset_cnt - r0 !== 0)) begin
      tests_failed++;
      $display("FAIL nack_no_retry: pings=%0d resets=%0d, required 1 0", ping_cnt - p0, reset_cnt - r0);
    end
  endtask

  task automatic test_back_to_back();
    pulse_req(1'b1, 8'h11, 8'h22);
    pulse_req(1'b0, 8'h99, 8'h00);
    tests_run++;
    if (pl_tx_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_req_ignored: pl_tx_en=%b, required 0", pl_tx_en);
    end
    pulse_tx_done();
    tests_run++;
    if (pl_tx_data !== 24'h0B1122) begin
      tests_failed++;
      $display("FAIL busy_frame_kept: data=%h, required 0b1122", pl_tx_data);
    end
    pulse_tx_done();
    pulse_sping();
    pulse_rx(16'h0008, 1'b0, 1'b0);
    tick();
    pulse_req(1'b0, 8'h77, 8'h00);
    tests_run++;
    if ({busy, pl_tx_en} !== 2'b00) begin
      tests_failed++;
      $display("FAIL done_cycle_req_ignored: busy/en=%b, required 00", {busy, pl_tx_en});
    end
    pulse_req(1'b0, 8'h55, 8'h00);
    tests_run++;
    if ({busy, pl_tx_en, pl_tx_type} !== 3'b110) begin
      tests_failed++;
      $display("FAIL b2b_accept: busy/en/type=%b, required 110", {busy, pl_tx_en, pl_tx_type});
    end
    pulse_tx_done();
    tests_run++;
    if (pl_tx_data !== 24'h000C55) begin
      tests_failed++;
      $display("FAIL b2b_frame: data=%h, required 000c55", pl_tx_data);
    end
    pulse_tx_done();
    pulse_sping();
    pulse_rx(16'h08C3, 1'b0, 1'b0);
    tick();
    tests_run++;
    if ({cmd_done, cmd_status, cmd_rdata} !== {1'b1, 2'b00, 8'hC3}) begin
      tests_failed++;
      $display("FAIL b2b_done: done=%b st=%b rd=%h, required 1 00 c3", cmd_done, cmd_status, cmd_rdata);
    end
    tick();
  endtask

  task automatic test_timeout();
    int p0 = ping_cnt;
    int f0 = frame_cnt;
    int r0 = reset_cnt;
    pulse_req(1'b1, 8'h01, 8'h02);
    for (int a = 0; a <= MR; a++) begin
      int n = 0;
      pulse_tx_done();
      pulse_tx_done();
      while (!pl_tx_en && !pl_tx_reset && n < 100) begin
        tick();
        n++;
      end
      tests_run++;
      if (n !== TO + 1) begin
        tests_failed++;
        $display("FAIL to_wait_len[%0d]: %0d cycles, required %0d", a, n, TO + 1);
      end
      tests_run++;
      if (a < MR && {pl_tx_en, pl_tx_type, pl_tx_reset} !== 3'b100) begin
        tests_failed++;
        $display("FAIL to_retry_ping[%0d]: en/type/rst=%b, required 100", a, {pl_tx_en, pl_tx_type, pl_tx_reset});
      end else if (a == MR && {pl_tx_en, pl_tx_reset, cmd_done} !== 3'b010) begin
        tests_failed++;
        $display("FAIL to_tx_reset: en/rst/done=%b, required 010", {pl_tx_en, pl_tx_reset, cmd_done});
      end
    end
    tick();
    tests_run++;
    if ({cmd_done, cmd_status, cmd_rdata, pl_tx_reset} !== {1'b1, 2'b10, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL to_done: done=%b st=%b rd=%h rst=%b, required 1 10 00 0", cmd_done, cmd_status, cmd_rdata, pl_tx_reset);
    end
    tick();
    tests_run++;
    if ((ping_cnt - p0 !== 3) || (frame_cnt - f0 !== 3) || (reset_cnt - r0 !== 1)) begin
      tests_failed++;
      $display("FAIL to_counts: pings=%0d frames=%0d resets=%0d, required 3 3 1",
               ping_cnt - p0, frame_cnt - f0, reset_cnt - r0);
    end
  endtask

  task automatic test_crc_retry();
    int p0 = ping_cnt;
    int r0 = reset_cnt;
    pulse_req(1'b0, 8'h33, 8'h00);
    pulse_tx_done();
    pulse_tx_done();
    pulse_sping();
    pulse_rx(16'h0811, 1'b1, 1'b0);
    tests_run++;
    if ({pl_tx_en, pl_tx_type, cmd_done} !== 3'b100) begin
      tests_failed++;
      $display("FAIL crc_retry_ping: en/type/done=%b, required 100", {pl_tx_en, pl_tx_type, cmd_done});
    end
    pulse_tx_done();
    pulse_tx_done();
    pulse_rx(16'h0808, 1'b0, 1'b0);
    pulse_tx_done();
    tick();
    tick();
    tests_run++;
    if ({cmd_done, pl_tx_en, pl_tx_reset} !== 3'b000) begin
      tests_failed++;
      $display("FAIL wait_ignores_rx: done/en/rst=%b, required 000", {cmd_done, pl_tx_en, pl_tx_reset});
    end
    pulse_sping();
    pulse_rx(16'h0877, 1'b0, 1'b0);
    tick();
    tests_run++;
    if ({cmd_done, cmd_status, cmd_rdata} !== {1'b1, 2'b00, 8'h77}) begin
      tests_failed++;
      $display("FAIL crc_retry_done: done=%b st=%b rd=%h, required 1 00 77", cmd_done, cmd_status, cmd_rdata);
    end
    tick();
    tests_run++;
    if ((ping_cnt - p0 !== 2) || (reset_cnt - r0 !== 0)) begin
      tests_failed++;
      $display("FAIL crc_counts: pings=%0d resets=%0d, required 2 0", ping_cnt - p0, reset_cnt - r0);
    end
  endtask

  task automatic test_link_error();
    pulse_req(1'b1, 8'h05, 8'h06);
    for (int a = 0; a <= MR; a++) begin
      pulse_tx_done();
      pulse_tx_done();
      pulse_sping();
      pulse_rx(16'h0008, 1'b0, 1'b1);
      tests_run++;
      if (a < MR && {pl_tx_en, pl_tx_type, pl_tx_reset} !== 3'b100) begin
        tests_failed++;
        $display("FAIL par_retry[%0d]: en/type/rst=%b, required 100", a, {pl_tx_en, pl_tx_type, pl_tx_reset});
      end else if (a == MR && {pl_tx_en, pl_tx_reset} !== 2'b01) begin
        tests_failed++;
        $display("FAIL par_tx_reset: en/rst=%b, required 01", {pl_tx_en, pl_tx_reset});
      end
    end
    tick();
    tests_run++;
    if ({cmd_done, cmd_status, cmd_rdata} !== {1'b1, 2'b11, 8'h00}) begin
      tests_failed++;
      $display("FAIL link_done: done=%b st=%b rd=%h, required 1 11 00", cmd_done, cmd_status, cmd_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    int r0 = reset_cnt;
    pulse_req(1'b0, 8'h10, 8'h00);
    pulse_tx_done();
    pulse_tx_done();
    pulse_sping();
    tick();
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, cmd_done, cmd_status, cmd_rdata, pl_tx_en, pl_tx_type, pl_tx_data, pl_tx_reset} !== 39'd0) begin
      tests_failed++;
      $display("FAIL async_reset: busy=%b done=%b st=%b rd=%h en=%b ty=%b dat=%h rst=%b, all zero required",
               busy, cmd_done, cmd_status, cmd_rdata, pl_tx_en, pl_tx_type, pl_tx_data, pl_tx_reset);
    end
    tick();
    rst = 1'b0;
    pulse_rx(16'h0800, 1'b0, 1'b0);
    tick();
    tick();
    tests_run++;
    if ((done_cnt - d0 !== 0) || (reset_cnt - r0 !== 0) || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_done: dones=%0d resets=%0d busy=%b, required 0 0 0", done_cnt - d0, reset_cnt - r0, busy);
    end
    pulse_req(1'b0, 8'h10, 8'h00);
    pulse_tx_done();
    tests_run++;
    if (pl_tx_data !== 24'h000C10) begin
      tests_failed++;
      $display("FAIL post_reset_frame: data=%h, required 000c10", pl_tx_data);
    end
    pulse_tx_done();
    pulse_sping();
    pulse_rx(16'h08AB, 1'b0, 1'b0);
    tick();
    tests_run++;
    if ({cmd_done, cmd_status, cmd_rdata} !== {1'b1, 2'b00, 8'hAB}) begin
      tests_failed++;
      $display("FAIL post_reset_done: done=%b st=%b rd=%h, required 1 00 ab", cmd_done, cmd_status, cmd_rdata);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    cmd_req = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    tx_done = 1'b0; ping_from_slave = 1'b0; rx_data = 16'h0000;
    rx_data_valid = 1'b0; crc_error = 1'b0; par_error = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_back_to_back();
    test_timeout();
    test_crc_retry();
    test_link_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fcp_master_logical_layer.md
# fcp_master_logical_layer

Initiator-side logical layer for the FCP single-wire link: the master that talks to the slave logical layer across the physical layer. Accepts register read/write requests from a host controller, builds the SBRWR/SBRRD command frames, and sequences ping → command → slave ping → slave response through the master physical layer. Applies a response timeout and a retry budget, and reports ACK/NACK/timeout/link-error status with read data to the host.

## Interface
- TIMEOUT, 16'd2000, cycles allowed in each wait state before a timeout is declared; legal range 1..65535.
- MAX_RETRY, 2, retries after a timeout or link error before giving up; legal range 0..3.
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- cmd_req  input  1  host request pulse; sampled only in IDLE.
- cmd_wr  input  1  1 = register write, 0 = register read.
- cmd_addr  input  8  slave register address.
- cmd_wdata  input  8  write data; ignored for reads.
- busy  output  1  high from the cycle after acceptance until the cycle after cmd_done.
- cmd_done  output  1  one-cycle completion pulse.
- cmd_status  output  2  00 ACK, 01 NACK, 10 timeout, 11 link error (CRC/parity); valid with cmd_done and held until the next cmd_done.
- cmd_rdata  output  8  read data; valid with cmd_done on a read with ACK status, otherwise 8'h00.
- pl_tx_en  output  1  one-cycle transmit strobe to the physical layer.
- pl_tx_type  output  1  0 = ping, 1 = command frame; valid with pl_tx_en.
- pl_tx_data  output  24  command frame; valid with pl_tx_en when pl_tx_type = 1.
- pl_tx_reset  output  1  one-cycle strobe requesting an FCP reset pulse on the wire.
- tx_done  input  1  physical layer finished the current transmission (pulse).
- ping_from_slave  input  1  slave ping detected (pulse).
- rx_data  input  16  received slave response frame.
- rx_data_valid  input  1  rx_data valid (pulse).
- crc_error  input  1  CRC error on the received frame (pulse).
- par_error  input  1  parity error on the received frame (pulse).

## Operation
- Frames: write = {8'h0B, addr, wdata}; read = {8'h00, 8'h0C, addr}. ACK = 8'h08, NACK = 8'h03.
- Response decode: for a write, RESP = rx_data[7:0]; for a read, RESP = rx_data[15:8] and data = rx_data[7:0]. RESP = ACK gives status 00. Any other value gives status 01 with cmd_rdata = 0. NACK is not retried.
- States: IDLE, TX_PING, TX_CMD, WAIT_SPING, WAIT_RESP, DONE.
  - IDLE: on cmd_req, latch cmd_wr, cmd_addr and cmd_wdata, clear retry_cnt, pulse pl_tx_en with pl_tx_type = 0, go to TX_PING.
  - TX_PING: on tx_done, pulse pl_tx_en with pl_tx_type = 1 and the frame, go to TX_CMD.
  - TX_CMD: on tx_done, clear the timer, go to WAIT_SPING.
  - WAIT_SPING: on ping_from_slave, clear the timer, go to WAIT_RESP. On timer == TIMEOUT, record a timeout fault.
  - WAIT_RESP: crc_error or par_error records a link-error fault; this has priority over rx_data_valid in the same cycle. Otherwise rx_data_valid decodes the response and goes to DONE. Timer == TIMEOUT records a timeout fault.
  - Fault handling: if retry_cnt < MAX_RETRY, increment retry_cnt, clear the timer, pulse a ping, and go to TX_PING. Otherwise pulse pl_tx_reset, set status to the fault code, and go to DONE.
  - DONE: pulse cmd_done for one cycle, go to IDLE.
- Timer: 16-bit, counts up by 1 per cycle in the wait states only; saturates, never wraps.
- Inputs that arrive outside their consuming state are ignored: tx_done in a wait state, ping_from_slave in a TX state, rx_data_valid outside WAIT_RESP.
- cmd_req while busy is ignored; there is no queue.
- Asynchronous reset mid-operation forces IDLE with no cmd_done and no pl_tx_reset.

## Timing
- Reset values: busy 0, cmd_done 0, cmd_status 00, cmd_rdata 8'h00, pl_tx_en 0, pl_tx_type 0, pl_tx_data 0, pl_tx_reset 0; state IDLE, timer 0, retry_cnt 0.
- All outputs are registered.
- pl_tx_en for the ping appears the cycle after cmd_req; busy rises in the same cycle.
- The command pl_tx_en appears the cycle after the ping's tx_done.
- cmd_done appears 2 cycles after the accepting rx_data_valid: decode, then DONE. busy falls the cycle after cmd_done.
- Timeout fires when the timer reaches TIMEOUT, i.e. TIMEOUT+1 cycles after entering the wait state.
- A retry ping is issued the cycle after the fault. pl_tx_reset is issued the cycle after the final fault, coincident with entering DONE.
- cmd_req accepted in the cycle after cmd_done: yes; IDLE is one cycle minimum.

## Test plan
- Write addr 8'h2C, data 8'd90: expect pl_tx_data = 24'h0B2C5A. Slave ping, then rx_data = 16'h0008 → cmd_done, status 00, 0 retries.
- Read addr 8'h29: expect frame 24'h000C29. rx_data = 16'h085A → status 00, cmd_rdata = 8'h5A.
- Read addr 8'h40, rx_data = 16'h0300 → status 01, cmd_rdata = 8'h00, no retry ping issued.
- TIMEOUT = 20, MAX_RETRY = 2, slave never pings → 3 ping/command sequences, each wait lasting 21 cycles; then pl_tx_reset pulse, status 10.
- crc_error and rx_data_valid in the same cycle on the first attempt, clean ACK on the retry → exactly one retry, status 00.
- rst asserted in WAIT_RESP, then released → all outputs at reset values, no cmd_done. A new cmd_req completes normally.
